// File: rtl/sna_flit_assembler_if.sv
// ---------------------------------------------------------------------------
// sna_flit_assembler_if
//
// Purpose:
//   Bundles the two handshakes of the SNA request-path unboxer into one port.
//   - The flit stream goes into the assembler.
//   - The assembled request and the error reporting come out of it.
//
// Modports:
//   slave  - the assembler side.
//            Inputs:  flit_in, flit_valid, req_ready.
//            Outputs: flit_ready, req_*, err_pulse, err_cnt.
//   master - the environment side (flit source plus request sink).
//            Same signals with the directions reversed.
//
// Parameters mirror sna_flit_assembler:
//   DATA_W, ADDR_W, POV_W, ERR_CNT_W.
//   The flit width is DATA_W+5.
// ---------------------------------------------------------------------------
interface sna_flit_assembler_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int POV_W     = 4,
    parameter int ERR_CNT_W = 8
);
    localparam int FLIT_W = DATA_W + 5;

    logic [FLIT_W-1:0]    flit_in;
    logic                 flit_valid;
    logic                 flit_ready;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_read;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_data;
    logic [POV_W-1:0]     req_src;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport slave (
        input  flit_in, flit_valid, req_ready,
        output flit_ready, req_valid, req_read, req_addr, req_data, req_src,
               err_pulse, err_cnt
    );

    modport master (
        output flit_in, flit_valid, req_ready,
        input  flit_ready, req_valid, req_read, req_addr, req_data, req_src,
               err_pulse, err_cnt
    );
endinterface

// File: rtl/sna_flit_assembler.sv
// ---------------------------------------------------------------------------
// sna_flit_assembler
//
// Purpose:
//   Request-path unboxer for the slave network adapter.
//   - Collects a head flit, an address flit and, for writes, a data flit.
//   - Assembles them into one registered AXI4-Lite-bound request.
//   - Presents that request downstream over a valid/ready handshake.
//   - Discards malformed flit sequences and reports each discarded flit
//     with a one-cycle err_pulse.
//
// Flit format:
//   The flit type is in the top two bits:
//     10 = head, 00 = address, 01 = data, 11 = reserved.
//   The payload is in bits [DATA_W-1:0].
//   Head payload: bit 0 = read, bits [24+POV_W-1:24] = source.
//
// Ports:
//   clk   - rising-edge clock.
//   rst_n - asynchronous active-low reset.
//   bus   - sna_flit_assembler_if.slave.
//           Carries the flit handshake, the request handshake and its
//           fields, err_pulse and err_cnt.
//
// Optional feature (macro SNA_FLIT_ERR_CNT_EN):
//   Defined   - err_cnt counts err_pulses and saturates at all-ones.
//   Undefined - err_cnt is tied to zero.
// ---------------------------------------------------------------------------
module sna_flit_assembler #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int POV_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    sna_flit_assembler_if.slave bus
);
    localparam int FLIT_W = DATA_W + 5;

    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_ADDR = 2'b00;
    localparam logic [1:0] FT_DATA = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        flit_type;
    logic              flit_acc;
    logic              latch_head;
    logic              latch_addr;
    logic              latch_data;
    logic              err_d;

    logic              req_valid_q;
    logic              req_read_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic [POV_W-1:0]  req_src_q;
    logic              err_pulse_q;

    // The three spare bits between the type field and the payload carry
    // nothing for this block.
    logic              unused_flit_bits;

    assign unused_flit_bits = ^bus.flit_in[FLIT_W-3:DATA_W];
    assign flit_type        = bus.flit_in[FLIT_W-1:FLIT_W-2];

    // Ready depends on state only, so the flit source never sees a
    // combinational loop through flit_valid.
    assign bus.flit_ready = (state_q != ST_HOLD);
    assign flit_acc       = bus.flit_valid && bus.flit_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and latch enables.
    // A head flit always restarts assembly, even mid-packet.
    // Any other unexpected flit throws the partial packet away and returns
    // to IDLE.
    always_comb begin
        state_d    = state_q;
        latch_head = 1'b0;
        latch_addr = 1'b0;
        latch_data = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flit_acc) begin
                    if (flit_type == FT_HEAD) begin
                        latch_head = 1'b1;
                        state_d    = ST_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (flit_acc) begin
                    if (flit_type == FT_HEAD) begin
                        latch_head = 1'b1;
                        err_d      = 1'b1;
                        state_d    = ST_ADDR;
                    end else if (flit_type == FT_ADDR) begin
                        latch_addr = 1'b1;
                        // The read flag was captured from the head flit.
                        state_d    = req_read_q ? ST_HOLD : ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (flit_acc) begin
                    if (flit_type == FT_HEAD) begin
                        latch_head = 1'b1;
                        err_d      = 1'b1;
                        state_d    = ST_ADDR;
                    end else if (flit_type == FT_DATA) begin
                        latch_data = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.req_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request registers.
    // Fields only change when their flit is accepted.
    // No flit is accepted in HOLD, so the presented request stays stable
    // until the handshake.
    // req_valid is registered from the next state, so it rises the cycle
    // after the final flit is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            req_read_q  <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_src_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            req_valid_q <= (state_d == ST_HOLD);
            err_pulse_q <= err_d;
            if (latch_head) begin
                req_read_q <= bus.flit_in[0];
                req_src_q  <= bus.flit_in[24+POV_W-1:24];
            end
            if (latch_addr) begin
                req_addr_q <= bus.flit_in[ADDR_W-1:0];
            end
            if (latch_data) begin
                req_data_q <= bus.flit_in[DATA_W-1:0];
            end
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_read  = req_read_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_data  = req_data_q;
    assign bus.req_src   = req_src_q;
    assign bus.err_pulse = err_pulse_q;

`ifdef SNA_FLIT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating error counter.
    // It steps on the same edge that raises err_pulse, so it is already
    // up to date while the pulse is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_sna_flit_assembler.sv
// ---------------------------------------------------------------------------
// tb_sna_flit_assembler
//
// Self-checking bench for sna_flit_assembler.
//
// Sections:
//   - A table of whole request vectors (inputs plus expected outputs).
//   - Hand-written sequences for restart, malformed flits, counter
//     saturation and reset mid-packet.
//   - A randomized flit stream checked against a packet-level reference
//     model.
//
// err_cnt expectations follow SNA_FLIT_ERR_CNT_EN, the same macro the
// design uses.
// ---------------------------------------------------------------------------
module tb_sna_flit_assembler;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int POV_W     = 4;
    localparam int ERR_CNT_W = 8;
    localparam int FLIT_W    = DATA_W + 5;

    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_ADDR = 2'b00;
    localparam logic [1:0] T_DATA = 2'b01;
    localparam logic [1:0] T_RSVD = 2'b11;

    logic clk;
    logic rst_n;

    sna_flit_assembler_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POV_W(POV_W), .ERR_CNT_W(ERR_CNT_W)
    ) bus ();

    sna_flit_assembler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POV_W(POV_W), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock.
    // Posedges fall at 5, 15, 25 and so on.
    // Negedges are used for sampling and driving.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int err_total     = 0;

    // Reference model state for the random phase.
    logic [FLIT_W-1:0] pkt[$];
    logic              m_busy;
    logic              m_err;
    logic              m_read;
    logic [POV_W-1:0]  m_src;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_last_data;

    typedef struct {
        logic        read;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        logic        exp_read;
        logic [3:0]  exp_src;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [FLIT_W-1:0] mk_flit(logic [1:0] t, logic [DATA_W-1:0] p);
        return {t, 3'b000, p};
    endfunction

    function automatic logic [DATA_W-1:0] mk_head(logic rd, logic [POV_W-1:0] src);
        logic [DATA_W-1:0] p;
        p = '0;
        p[24 +: POV_W] = src;
        p[0] = rd;
        return p;
    endfunction

    // Expected counter value for the number of errors so far.
    function automatic logic [ERR_CNT_W-1:0] exp_cnt();
`ifdef SNA_FLIT_ERR_CNT_EN
        if (err_total >= (1 << ERR_CNT_W) - 1) return '1;
        return ERR_CNT_W'(err_total);
`else
        return '0;
`endif
    endfunction

    task automatic check_output(string name, logic [63:0] actual, logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one flit for one cycle.
    // Called at a negedge; returns at the next negedge.
    task automatic drive_flit(logic [1:0] t, logic [DATA_W-1:0] p);
        bus.flit_in    = mk_flit(t, p);
        bus.flit_valid = 1'b1;
        @(negedge clk);
        bus.flit_valid = 1'b0;
    endtask

    // One-cycle request handshake.
    task automatic accept_request();
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        err_total   = 0;
        m_busy      = 1'b0;
        m_err       = 1'b0;
        m_last_data = '0;
        pkt.delete();
    endtask

    // Sends one whole packet from the vector table.
    // Checks the presented request, holds it for the stall count,
    // then completes the handshake.
    task automatic apply_stimulus(vec_t v);
        drive_flit(T_HEAD, mk_head(v.read, v.src));
        check_output("vec mid-packet req_valid", 64'(bus.req_valid), 64'(0));
        drive_flit(T_ADDR, v.addr);
        if (!v.read) begin
            check_output("vec before data req_valid", 64'(bus.req_valid), 64'(0));
            drive_flit(T_DATA, v.data);
        end
        check_output("vec req_valid", 64'(bus.req_valid), 64'(1));
        check_output("vec flit_ready in hold", 64'(bus.flit_ready), 64'(0));
        for (int k = 0; k < v.stall; k++) begin
            bus.flit_in    = mk_flit(T_HEAD, mk_head(1'b1, 4'h7));
            bus.flit_valid = 1'b1;
            @(negedge clk);
            check_output("stall req_valid", 64'(bus.req_valid), 64'(1));
            check_output("stall flit_ready", 64'(bus.flit_ready), 64'(0));
            check_output("stall req_addr", 64'(bus.req_addr), 64'(v.exp_addr));
            check_output("stall req_data", 64'(bus.req_data), 64'(v.exp_data));
        end
        bus.flit_valid = 1'b0;
        check_output("vec req_read", 64'(bus.req_read), 64'(v.exp_read));
        check_output("vec req_src", 64'(bus.req_src), 64'(v.exp_src));
        check_output("vec req_addr", 64'(bus.req_addr), 64'(v.exp_addr));
        check_output("vec req_data", 64'(bus.req_data), 64'(v.exp_data));
        check_output("vec err_pulse", 64'(bus.err_pulse), 64'(0));
        accept_request();
        check_output("vec req_valid after ready", 64'(bus.req_valid), 64'(0));
        check_output("vec flit_ready after ready", 64'(bus.flit_ready), 64'(1));
    endtask

    // Packet-level reference model.
    // It keeps the flits of the current packet in a queue and produces a
    // request once the queue holds a full read (2 flits) or a full
    // write (3 flits).
    task automatic model_step(logic valid, logic [FLIT_W-1:0] f, logic ready);
        logic [1:0] t;
        logic [1:0] wanted;
        m_err = 1'b0;
        t     = f[FLIT_W-1:FLIT_W-2];
        if (m_busy) begin
            if (ready) m_busy = 1'b0;
        end else if (valid) begin
            if (t == T_HEAD) begin
                if (pkt.size() != 0) m_err = 1'b1;
                pkt.delete();
                pkt.push_back(f);
            end else if (pkt.size() == 0) begin
                m_err = 1'b1;
            end else begin
                wanted = (pkt.size() == 1) ? T_ADDR : T_DATA;
                if (t == wanted) begin
                    pkt.push_back(f);
                end else begin
                    m_err = 1'b1;
                    pkt.delete();
                end
            end
            if ((pkt.size() == 2 && pkt[0][0]) || pkt.size() == 3) begin
                m_read = pkt[0][0];
                m_src  = pkt[0][24 +: POV_W];
                m_addr = pkt[1][ADDR_W-1:0];
                if (!m_read) m_last_data = pkt[2][DATA_W-1:0];
                m_busy = 1'b1;
                pkt.delete();
            end
        end
        if (m_err) err_total++;
    endtask

    // Watchdog.
    // Every section runs a fixed number of cycles; this only fires if
    // simulation time runs away.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic              rv;
        logic [1:0]        rt;
        logic [DATA_W-1:0] rp;
        logic              rr;
        logic [FLIT_W-1:0] rf;

        vecs[0] = '{1'b1, 4'h5, 32'h0000_1000, 32'h0,         0, 1'b1, 4'h5, 32'h0000_1000, 32'h0};
        vecs[1] = '{1'b0, 4'hA, 32'h0000_2000, 32'hDEAD_BEEF, 5, 1'b0, 4'hA, 32'h0000_2000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 4'h3, 32'h0000_0ABC, 32'h0,         2, 1'b1, 4'h3, 32'h0000_0ABC, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h1234_5678, 0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h1234_5678};
        vecs[4] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         1, 1'b1, 4'h0, 32'h0000_0000, 32'h1234_5678};

        rst_n          = 1'b0;
        bus.flit_in    = '0;
        bus.flit_valid = 1'b0;
        bus.req_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset req_valid", 64'(bus.req_valid), 64'(0));
        check_output("reset err_pulse", 64'(bus.err_pulse), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post-reset flit_ready", 64'(bus.flit_ready), 64'(1));
        check_output("post-reset req_read", 64'(bus.req_read), 64'(0));
        check_output("post-reset req_addr", 64'(bus.req_addr), 64'(0));
        check_output("post-reset req_data", 64'(bus.req_data), 64'(0));
        check_output("post-reset req_src", 64'(bus.req_src), 64'(0));
        check_output("post-reset err_cnt", 64'(bus.err_cnt), 64'(0));

        $display("[TB] table-driven request vectors");
        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

        $display("[TB] restart on second head");
        drive_flit(T_HEAD, mk_head(1'b0, 4'h1));
        drive_flit(T_HEAD, mk_head(1'b1, 4'h2));
        err_total++;
        check_output("restart err_pulse", 64'(bus.err_pulse), 64'(1));
        check_output("restart err_cnt", 64'(bus.err_cnt), 64'(exp_cnt()));
        drive_flit(T_ADDR, 32'h30);
        check_output("restart err_pulse clears", 64'(bus.err_pulse), 64'(0));
        check_output("restart req_valid", 64'(bus.req_valid), 64'(1));
        check_output("restart req_src", 64'(bus.req_src), 64'(2));
        check_output("restart req_addr", 64'(bus.req_addr), 64'(32'h30));
        check_output("restart req_read", 64'(bus.req_read), 64'(1));
        accept_request();

        $display("[TB] malformed sequences");
        do_reset();
        drive_flit(T_DATA, 32'h1111);
        err_total++;
        check_output("data in idle err_pulse", 64'(bus.err_pulse), 64'(1));
        drive_flit(T_HEAD, mk_head(1'b1, 4'h7));
        check_output("head after error err_pulse", 64'(bus.err_pulse), 64'(0));
        drive_flit(T_RSVD, 32'h0);
        err_total++;
        check_output("reserved in addr err_pulse", 64'(bus.err_pulse), 64'(1));
        @(negedge clk);
        check_output("malformed req_valid", 64'(bus.req_valid), 64'(0));
        check_output("malformed flit_ready", 64'(bus.flit_ready), 64'(1));
        check_output("malformed err_cnt", 64'(bus.err_cnt), 64'(exp_cnt()));
        // An address flit now only errors if the block really went back
        // to IDLE.
        drive_flit(T_ADDR, 32'h40);
        err_total++;
        check_output("addr in idle err_pulse", 64'(bus.err_pulse), 64'(1));
        check_output("addr in idle req_valid", 64'(bus.req_valid), 64'(0));

        $display("[TB] error counter saturation");
        bus.flit_in    = mk_flit(T_RSVD, 32'h0);
        bus.flit_valid = 1'b1;
        repeat (300) @(negedge clk);
        bus.flit_valid = 1'b0;
        err_total += 300;
        @(negedge clk);
        check_output("saturated err_cnt", 64'(bus.err_cnt), 64'(exp_cnt()));
        check_output("saturation err_pulse idle", 64'(bus.err_pulse), 64'(0));

        $display("[TB] reset mid-packet");
        drive_flit(T_HEAD, mk_head(1'b0, 4'h9));
        drive_flit(T_ADDR, 32'h44);
        #2 rst_n = 1'b0;
        #1;
        err_total = 0;
        check_output("reset in data req_addr", 64'(bus.req_addr), 64'(0));
        check_output("reset in data req_src", 64'(bus.req_src), 64'(0));
        check_output("reset in data err_cnt", 64'(bus.err_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive_flit(T_HEAD, mk_head(1'b0, 4'hB));
        drive_flit(T_ADDR, 32'h50);
        drive_flit(T_DATA, 32'hCAFE);
        check_output("pre-reset hold req_valid", 64'(bus.req_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_output("reset in hold req_valid", 64'(bus.req_valid), 64'(0));
        check_output("reset in hold req_data", 64'(bus.req_data), 64'(0));
        check_output("reset in hold req_addr", 64'(bus.req_addr), 64'(0));
        check_output("reset in hold req_read", 64'(bus.req_read), 64'(0));
        check_output("reset in hold req_src", 64'(bus.req_src), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("after reset flit_ready", 64'(bus.flit_ready), 64'(1));
        drive_flit(T_HEAD, mk_head(1'b1, 4'h6));
        drive_flit(T_ADDR, 32'h60);
        check_output("post-reset read req_valid", 64'(bus.req_valid), 64'(1));
        check_output("post-reset read req_addr", 64'(bus.req_addr), 64'(32'h60));
        check_output("post-reset read req_src", 64'(bus.req_src), 64'(6));
        check_output("post-reset read req_read", 64'(bus.req_read), 64'(1));
        check_output("post-reset read req_data", 64'(bus.req_data), 64'(0));
        accept_request();

        $display("[TB] randomized flit stream");
        do_reset();
        for (int c = 0; c < 800; c++) begin
            check_output("rnd flit_ready", 64'(bus.flit_ready), 64'(!m_busy));
            check_output("rnd req_valid", 64'(bus.req_valid), 64'(m_busy));
            check_output("rnd err_pulse", 64'(bus.err_pulse), 64'(m_err));
            check_output("rnd err_cnt", 64'(bus.err_cnt), 64'(exp_cnt()));
            if (m_busy) begin
                check_output("rnd req_read", 64'(bus.req_read), 64'(m_read));
                check_output("rnd req_src", 64'(bus.req_src), 64'(m_src));
                check_output("rnd req_addr", 64'(bus.req_addr), 64'(m_addr));
                check_output("rnd req_data", 64'(bus.req_data), 64'(m_last_data));
            end
            rv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) begin
                rt = (pkt.size() == 0) ? T_HEAD : (pkt.size() == 1) ? T_ADDR : T_DATA;
            end else begin
                rt = 2'($urandom_range(0, 3));
            end
            rp = $urandom;
            rr = ($urandom_range(0, 2) == 0);
            rf = mk_flit(rt, rp);
            bus.flit_in    = rf;
            bus.flit_valid = rv;
            bus.req_ready  = rr;
            model_step(rv, rf, rr);
            @(negedge clk);
        end
        bus.flit_valid = 1'b0;
        bus.req_ready  = 1'b0;

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
